tlul_reg_responder: RTL and testbench
=====================================

Name: tlul_reg_responder

Overview:
- Device-side TL-UL responder: terminates one xbar device port (e.g. GPIO, LDO, DCDC windows) and converts A-channel requests into a simple req/ack register-bus access.
- Returns D-channel responses, including protocol and decode errors and access timeouts.
- One outstanding transaction at a time; sits between the xbar device output and a peripheral's register file.

Parameters:
- BaseAddr, 32'h40080000, device window base address.
- AddrMask, 32'h0000ffff, window offset mask; in-window iff (a_address & ~AddrMask) == BaseAddr.
- TimeoutCycles, 16, max cycles in REQ without reg_ack_i before an error response (>=1).
- SrcW, 8, source ID width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- a_valid_i  in  1  A-channel valid.
- a_ready_o  out  1  A-channel ready.
- a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- a_size_i  in  2  log2 bytes.
- a_source_i  in  SrcW  requester ID.
- a_address_i  in  32  byte address.
- a_mask_i  in  4  byte lanes.
- a_data_i  in  32  write data.
- d_valid_o  out  1  D-channel valid.
- d_ready_i  in  1  D-channel ready.
- d_opcode_o  out  3  0=AccessAck, 1=AccessAckData.
- d_size_o  out  2  echoed a_size.
- d_source_o  out  SrcW  echoed a_source.
- d_data_o  out  32  read data.
- d_error_o  out  1  error flag.
- reg_req_o  out  1  register access request.
- reg_we_o  out  1  1=write.
- reg_addr_o  out  32  a_address & AddrMask, bits [1:0] forced 0.
- reg_wdata_o  out  32  write data.
- reg_be_o  out  4  byte enables.
- reg_ack_i  in  1  access complete.
- reg_rdata_i  in  32  read data, valid with ack.
- reg_err_i  in  1  peripheral error, valid with ack.

Behaviour:
- FSM states: IDLE, REQ, RSP. Reset enters IDLE; all outputs 0 except a_ready_o=1 (a_ready_o = state==IDLE).
- IDLE, on a_valid&a_ready: latch opcode, size, source, address, mask, data.
  - Error checks: opcode not in {0,1,4}; size>2; address not aligned to size; out of window; PutFull with mask != 4'hF at size 2.
  - Any check fails -> RSP with d_error=1, no register access.
  - Otherwise -> REQ with timeout counter cleared.
- REQ:
  - reg_req_o=1; reg_we_o=(opcode!=Get); reg_be_o=mask for Put, 4'hF for Get. All reg_* held stable.
  - On reg_ack_i: capture rdata (Get only; Put returns 0) and err -> RSP.
  - Else counter+1. Counter reaching TimeoutCycles-1 without ack -> RSP with d_error=1, d_data=0.
  - Ack in the same cycle as timeout: ack wins.
- RSP:
  - d_valid_o=1, fields registered and stable until d_ready_i. d_opcode=1 for Get, 0 for Put.
  - d_data=0 whenever d_error=1.
  - On d_ready_i -> IDLE. a_ready_o reasserts the following cycle; no back-to-back acceptance in the RSP handshake cycle.
- Latency, accept at edge N:
  - Error path: d_valid in cycle N+1.
  - Ack in first REQ cycle: reg_req in N+1, d_valid from N+2.
- reg_ack_i outside REQ (late ack after timeout) is ignored, with no effect on state or data.
- Async reset mid-transaction: immediate IDLE, reg_req_o/d_valid_o drop to 0, transaction lost.

Decomposition:
- Shared package tlul_pkg holds the opcode enums (PutFullData/PutPartialData/Get; AccessAck/AccessAckData) and the size constants.
- Device BaseAddr/AddrMask instance values come from the xbar address-map package.
- No sub-module; single FSM plus timeout counter.

Test Plan:
- Get 0x40080010, ack after 2 cycles with rdata 0xDEADBEEF -> d_valid N+4, opcode 1, data 0xDEADBEEF, error 0, source echoed.
- PutPartial 0x40080004 mask 4'b0011 data 0x1234 -> reg_we=1, be=0011, reg_addr 0x4; d_opcode 0, error 0.
- Get 0x40090000 (out of window), or misaligned 0x40080002 size 2 -> no reg_req; d_valid N+1, error 1, data 0.
- Get with no ack (TimeoutCycles=16) -> reg_req high 16 cycles, then error response; later ack ignored.
- Response with d_ready low 5 cycles -> d_* stable, a_ready low; second request accepted only after the handshake.
- rst_ni low during REQ -> reg_req_o and d_valid_o 0 at once; clean Get succeeds after release.

Source files
------------

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL opcode enums, size constants and request legality check
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_opcode_e;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  // Any reason an A-channel request must be answered with an error and no register access.
  function automatic logic a_req_illegal(
    input logic [2:0]  op,
    input logic [1:0]  size,
    input logic [31:0] addr,
    input logic [3:0]  mask,
    input logic [31:0] base,
    input logic [31:0] win_mask
  );
    logic       op_bad;
    logic       size_bad;
    logic       misaligned;
    logic       out_of_window;
    logic       put_full_bad;
    logic [1:0] lsb_mask;
    op_bad        = !(op == PutFullData || op == PutPartialData || op == Get);
    size_bad      = (size > SizeWord);
    lsb_mask      = (size == SizeByte) ? 2'b00 : (size == SizeHalf) ? 2'b01 : 2'b11;
    misaligned    = |(addr[1:0] & lsb_mask);
    out_of_window = ((addr & ~win_mask) != base);
    put_full_bad  = (op == PutFullData) && (size == SizeWord) && (mask != 4'hF);
    return op_bad | size_bad | misaligned | out_of_window | put_full_bad;
  endfunction

endpackage

// File: rtl/tlul_reg_responder.sv
// rtl/tlul_reg_responder.sv - TL-UL device port to req/ack register bus, one transaction in flight
module tlul_reg_responder
  import tlul_pkg::*;
#(
  parameter logic [31:0] BaseAddr      = 32'h40080000,
  parameter logic [31:0] AddrMask      = 32'h0000ffff,
  parameter int unsigned TimeoutCycles = 16,
  parameter int unsigned SrcW          = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic [2:0]      a_opcode_i,
  input  logic [1:0]      a_size_i,
  input  logic [SrcW-1:0] a_source_i,
  input  logic [31:0]     a_address_i,
  input  logic [3:0]      a_mask_i,
  input  logic [31:0]     a_data_i,
  output logic            d_valid_o,
  input  logic            d_ready_i,
  output logic [2:0]      d_opcode_o,
  output logic [1:0]      d_size_o,
  output logic [SrcW-1:0] d_source_o,
  output logic [31:0]     d_data_o,
  output logic            d_error_o,
  output logic            reg_req_o,
  output logic            reg_we_o,
  output logic [31:0]     reg_addr_o,
  output logic [31:0]     reg_wdata_o,
  output logic [3:0]      reg_be_o,
  input  logic            reg_ack_i,
  input  logic [31:0]     reg_rdata_i,
  input  logic            reg_err_i
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  state_e          r_state;
  logic [2:0]      r_opcode;
  logic [1:0]      r_size;
  logic [SrcW-1:0] r_source;
  logic [31:0]     r_addr;
  logic [3:0]      r_mask;
  logic [31:0]     r_wdata;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_d_opcode;
  logic [31:0]     r_d_data;
  logic            r_d_error;

  logic w_in_req;
  logic w_is_get;
  logic w_req_bad;

  assign w_in_req  = (r_state == StReq);
  assign w_is_get  = (r_opcode == Get);
  assign w_req_bad = a_req_illegal(a_opcode_i, a_size_i, a_address_i, a_mask_i, BaseAddr, AddrMask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_opcode   <= '0;
      r_size     <= '0;
      r_source   <= '0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_d_opcode <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (a_valid_i) begin
            r_opcode   <= a_opcode_i;
            r_size     <= a_size_i;
            r_source   <= a_source_i;
            r_addr     <= a_address_i;
            r_mask     <= a_mask_i;
            r_wdata    <= a_data_i;
            r_cnt      <= '0;
            r_d_opcode <= (a_opcode_i == Get) ? AccessAckData : AccessAck;
            r_d_data   <= '0;
            r_d_error  <= w_req_bad;
            r_state    <= w_req_bad ? StRsp : StReq;
          end
        end
        StReq: begin
          // An ack arriving on the final timeout cycle still completes normally.
          if (reg_ack_i) begin
            r_d_error <= reg_err_i;
            r_d_data  <= (w_is_get && !reg_err_i) ? reg_rdata_i : '0;
            r_state   <= StRsp;
          end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
            r_d_error <= 1'b1;
            r_d_data  <= '0;
            r_state   <= StRsp;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StRsp: begin
          if (d_ready_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign a_ready_o   = (r_state == StIdle);
  assign d_valid_o   = (r_state == StRsp);
  assign d_opcode_o  = r_d_opcode;
  assign d_size_o    = r_size;
  assign d_source_o  = r_source;
  assign d_data_o    = r_d_data;
  assign d_error_o   = r_d_error;

  // Register-bus outputs are only driven while a request is in flight.
  assign reg_req_o   = w_in_req;
  assign reg_we_o    = w_in_req && !w_is_get;
  assign reg_addr_o  = w_in_req ? (r_addr & AddrMask & 32'hFFFF_FFFC) : '0;
  assign reg_wdata_o = w_in_req ? r_wdata : '0;
  assign reg_be_o    = !w_in_req ? 4'h0 : w_is_get ? 4'hF : r_mask;

endmodule

// File: tb/tb_tlul_reg_responder.sv
// tb/tb_tlul_reg_responder.sv - randomized self-checking bench for tlul_reg_responder
module tb_tlul_reg_responder;

  localparam int          T     = 16;
  localparam logic [31:0] BASE  = 32'h40080000;
  localparam logic [31:0] WMASK = 32'h0000ffff;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        a_valid_i = 1'b0;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i = '0;
  logic [1:0]  a_size_i = '0;
  logic [7:0]  a_source_i = '0;
  logic [31:0] a_address_i = '0;
  logic [3:0]  a_mask_i = '0;
  logic [31:0] a_data_i = '0;
  logic        d_valid_o;
  logic        d_ready_i = 1'b0;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [7:0]  d_source_o;
  logic [31:0] d_data_o;
  logic        d_error_o;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_be_o;
  logic        reg_ack_i = 1'b0;
  logic [31:0] reg_rdata_i = '0;
  logic        reg_err_i = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  tlul_reg_responder #(
    .BaseAddr(BASE), .AddrMask(WMASK), .TimeoutCycles(T), .SrcW(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
    .a_size_i(a_size_i), .a_source_i(a_source_i), .a_address_i(a_address_i),
    .a_mask_i(a_mask_i), .a_data_i(a_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
    .d_size_o(d_size_o), .d_source_o(d_source_o), .d_data_o(d_data_o),
    .d_error_o(d_error_o),
    .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o), .reg_ack_i(reg_ack_i),
    .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          aready0;
    int          req_cycles;
    int          dvalid_cycle;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_stable;
    logic [2:0]  dop;
    logic [1:0]  dsize;
    logic [7:0]  dsrc;
    logic [31:0] ddata;
    logic        derr;
    int          d_stable;
    int          ardy_in_rsp;
    int          ardy_after;
  } obs_t;

  // Reference: what a transaction should look like, cycles counted from the accepting edge.
  function automatic obs_t model(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                                 input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                                 input int ack_delay, input logic [31:0] rdata, input logic err);
    obs_t e;
    bit   bad;
    int   bytes;
    bytes = 1 << size;
    bad = !(op == 0 || op == 1 || op == 4) || size > 2 || (addr % bytes) != 0 ||
          (addr & ~WMASK) != BASE || (op == 0 && size == 2 && mask != 4'hF);
    e = '{default: 0};
    e.aready0 = 1; e.req_stable = 1; e.d_stable = 1; e.ardy_in_rsp = 0; e.ardy_after = 1;
    e.dop = (op == 4) ? 3'd1 : 3'd0;
    e.dsize = size; e.dsrc = src;
    e.we = (op != 4);
    e.addr = (addr & WMASK) & 32'hFFFF_FFFC;
    e.be = (op == 4) ? 4'hF : mask;
    e.wdata = data;
    if (bad) begin
      e.req_cycles = 0; e.dvalid_cycle = 1; e.derr = 1; e.ddata = 0;
    end else if (ack_delay >= 0 && ack_delay < T) begin
      e.req_cycles = ack_delay + 1; e.dvalid_cycle = ack_delay + 2;
      e.derr = err; e.ddata = (err || op != 4) ? 32'h0 : rdata;
    end else begin
      e.req_cycles = T; e.dvalid_cycle = T + 1; e.derr = 1; e.ddata = 0;
    end
    return e;
  endfunction

  function automatic string fmt_timing(input obs_t o);
    return $sformatf("rdy0=%0d req_cyc=%0d dvalid_at=%0d", o.aready0, o.req_cycles, o.dvalid_cycle);
  endfunction
  function automatic string fmt_rsp(input obs_t o);
    return $sformatf("op=%0d size=%0d src=%h err=%b data=%h", o.dop, o.dsize, o.dsrc, o.derr, o.ddata);
  endfunction
  function automatic string fmt_reg(input obs_t o);
    return $sformatf("we=%b addr=%h be=%b wdata=%h stable=%0d", o.we, o.addr, o.be, o.wdata, o.req_stable);
  endfunction
  function automatic string fmt_hs(input obs_t o);
    return $sformatf("d_stable=%0d ardy_in_rsp=%0d ardy_after=%0d", o.d_stable, o.ardy_in_rsp, o.ardy_after);
  endfunction

  // Runs one request to completion; ack_delay<0 means never ack (late acks are then thrown in during RSP).
  task automatic drive_txn(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                           input int ack_delay, input logic [31:0] rdata, input logic err,
                           input int dr_delay, output obs_t o);
    int c;
    int k;
    bit done;
    o = '{default: 0};
    o.req_stable = 1; o.d_stable = 1; o.dvalid_cycle = -1;
    o.aready0 = a_ready_o;
    a_valid_i = 1'b1; a_opcode_i = op; a_size_i = size; a_source_i = src;
    a_address_i = addr; a_mask_i = mask; a_data_i = data;
    @(posedge clk_i); #1;
    a_valid_i = 1'b0; a_opcode_i = 3'($urandom); a_size_i = 2'($urandom); a_source_i = 8'($urandom);
    a_address_i = $urandom; a_mask_i = 4'($urandom); a_data_i = $urandom;
    c = 1; k = 0; done = 0;
    while (!done && c < 60) begin
      reg_ack_i = 1'b0; reg_rdata_i = $urandom; reg_err_i = 1'($urandom);
      if (reg_req_o) begin
        if (k == 0) begin
          o.we = reg_we_o; o.addr = reg_addr_o; o.be = reg_be_o; o.wdata = reg_wdata_o;
        end else if ({reg_we_o, reg_addr_o, reg_be_o, reg_wdata_o} !== {o.we, o.addr, o.be, o.wdata}) begin
          o.req_stable = 0;
        end
        if (k == ack_delay) begin
          reg_ack_i = 1'b1; reg_rdata_i = rdata; reg_err_i = err;
        end
        k++;
      end
      if (d_valid_o) begin
        o.dvalid_cycle = c;
        o.dop = d_opcode_o; o.dsize = d_size_o; o.dsrc = d_source_o; o.ddata = d_data_o; o.derr = d_error_o;
        if (a_ready_o) o.ardy_in_rsp = 1;
        for (int w = 0; w < dr_delay; w++) begin
          d_ready_i = 1'b0;
          if (ack_delay < 0) begin
            reg_ack_i = 1'b1; reg_rdata_i = $urandom | 32'h1; reg_err_i = 1'b0;
          end
          @(posedge clk_i); #1;
          if (!d_valid_o || {d_opcode_o, d_size_o, d_source_o, d_data_o, d_error_o} !==
                            {o.dop, o.dsize, o.dsrc, o.ddata, o.derr}) o.d_stable = 0;
          if (a_ready_o) o.ardy_in_rsp = 1;
        end
        reg_ack_i = 1'b0; d_ready_i = 1'b1;
        @(posedge clk_i); #1;
        d_ready_i = 1'b0;
        o.ardy_after = (a_ready_o && !d_valid_o) ? 1 : 0;
        done = 1;
      end else begin
        @(posedge clk_i); #1;
        c++;
      end
    end
    o.req_cycles = k;
    reg_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({a_ready_o, d_valid_o, reg_req_o} !== 3'b100) begin
      n_fail++; $display("FAIL reset_handshake: got rdy/dv/req=%b want 100", {a_ready_o, d_valid_o, reg_req_o});
    end
    n_cmp++;
    if ({reg_we_o, reg_be_o, reg_addr_o, reg_wdata_o, d_opcode_o, d_size_o, d_source_o, d_data_o, d_error_o} !== '0) begin
      n_fail++; $display("FAIL reset_fields: got we=%b be=%h addr=%h wd=%h dop=%0d dsz=%0d src=%h dd=%h derr=%b want all 0",
                         reg_we_o, reg_be_o, reg_addr_o, reg_wdata_o, d_opcode_o, d_size_o, d_source_o, d_data_o, d_error_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_get_ack();
    obs_t o, e;
    logic [7:0] src;
    logic [31:0] addr, rd;
    int ad;
    logic err;
    src = 8'($urandom);
    drive_txn(3'd4, 2'd2, src, 32'h40080010, 4'hF, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, o);
    e = model(3'd4, 2'd2, src, 32'h40080010, 4'hF, 32'h0, 2, 32'hDEADBEEF, 1'b0);
    n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL get_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL get_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
    n_cmp++; if (fmt_reg(o) != fmt_reg(e)) begin n_fail++; $display("FAIL get_reg: got %s want %s", fmt_reg(o), fmt_reg(e)); end
    for (int i = 0; i < 4; i++) begin
      src = 8'($urandom); addr = BASE + ($urandom & 32'h0000FFFC); rd = $urandom;
      ad = $urandom_range(0, 5); err = ($urandom_range(0, 3) == 0);
      drive_txn(3'd4, 2'd2, src, addr, 4'($urandom), 32'h0, ad, rd, err, $urandom_range(0, 2), o);
      e = model(3'd4, 2'd2, src, addr, 4'hF, 32'h0, ad, rd, err);
      n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL get_rand_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
      n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL get_rand_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
    end
  endtask

  task automatic test_put_partial();
    obs_t o, e;
    logic [2:0] op;
    logic [3:0] mask;
    logic [31:0] addr, wd;
    drive_txn(3'd1, 2'd2, 8'h5A, 32'h40080004, 4'b0011, 32'h1234, 0, 32'hFFFFFFFF, 1'b0, 0, o);
    e = model(3'd1, 2'd2, 8'h5A, 32'h40080004, 4'b0011, 32'h1234, 0, 32'hFFFFFFFF, 1'b0);
    n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL put_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL put_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
    n_cmp++; if (fmt_reg(o) != fmt_reg(e)) begin n_fail++; $display("FAIL put_reg: got %s want %s", fmt_reg(o), fmt_reg(e)); end
    for (int i = 0; i < 4; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd1;
      mask = (op == 3'd0) ? 4'hF : 4'($urandom);
      addr = BASE + ($urandom & 32'h0000FFFC); wd = $urandom;
      drive_txn(op, 2'd2, 8'(i), addr, mask, wd, $urandom_range(0, 3), $urandom, 1'b0, 0, o);
      e = model(op, 2'd2, 8'(i), addr, mask, wd, 0, 32'h0, 1'b0);
      e.req_cycles = o.req_cycles; e.dvalid_cycle = o.req_cycles + 1;
      n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL put_rand_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
      n_cmp++; if (fmt_reg(o) != fmt_reg(e)) begin n_fail++; $display("FAIL put_rand_reg: got %s want %s", fmt_reg(o), fmt_reg(e)); end
    end
  endtask

  task automatic test_errors();
    obs_t o, e;
    logic [2:0]  ops   [9];
    logic [1:0]  sizes [9];
    logic [31:0] addrs [9];
    logic [3:0]  masks [9];
    logic [31:0] rd;
    ops   = '{3'd4, 3'd4, 3'd4, 3'd3, 3'd4, 3'd0, 3'd4, 3'd4, 3'd0};
    sizes = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0};
    addrs = '{32'h40090000, 32'h40080002, 32'h40080001, 32'h40080000, 32'h40080000,
              32'h40080008, 32'h4008FFFC, 32'h4007FFFC, 32'h40080003};
    masks = '{4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF, 4'h8};
    for (int i = 0; i < 9; i++) begin
      rd = $urandom;
      drive_txn(ops[i], sizes[i], 8'(8'h80 + i), addrs[i], masks[i], 32'hCAFE0000 + i, 1, rd, 1'b0, 0, o);
      e = model(ops[i], sizes[i], 8'(8'h80 + i), addrs[i], masks[i], 32'hCAFE0000 + i, 1, rd, 1'b0);
      n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL err_timing[%0d]: got %s want %s", i, fmt_timing(o), fmt_timing(e)); end
      n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL err_rsp[%0d]: got %s want %s", i, fmt_rsp(o), fmt_rsp(e)); end
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    bit idle_bad;
    drive_txn(3'd4, 2'd2, 8'h33, 32'h40080020, 4'hF, 32'h0, -1, 32'h0, 1'b0, 3, o);
    e = model(3'd4, 2'd2, 8'h33, 32'h40080020, 4'hF, 32'h0, -1, 32'h0, 1'b0);
    n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL timeout_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL timeout_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
    n_cmp++; if (fmt_hs(o) != fmt_hs(e)) begin n_fail++; $display("FAIL timeout_late_ack_hs: got %s want %s", fmt_hs(o), fmt_hs(e)); end
    idle_bad = 0;
    for (int i = 0; i < 3; i++) begin
      reg_ack_i = 1'b1; reg_rdata_i = $urandom; reg_err_i = 1'b1;
      @(posedge clk_i); #1;
      if (!a_ready_o || d_valid_o || reg_req_o) idle_bad = 1;
    end
    reg_ack_i = 1'b0;
    n_cmp++; if (idle_bad) begin n_fail++; $display("FAIL idle_late_ack: got state disturbed want rdy=1 dv=0 req=0"); end
    drive_txn(3'd4, 2'd2, 8'h34, 32'h40080024, 4'hF, 32'h0, T - 1, 32'h0BADF00D, 1'b0, 0, o);
    e = model(3'd4, 2'd2, 8'h34, 32'h40080024, 4'hF, 32'h0, T - 1, 32'h0BADF00D, 1'b0);
    n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL ack_at_limit_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL ack_at_limit_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [31:0] wd, rd;
    wd = $urandom; rd = $urandom;
    drive_txn(3'd1, 2'd2, 8'h11, 32'h40080040, 4'b1100, wd, 1, 32'h0, 1'b1, 5, o);
    e = model(3'd1, 2'd2, 8'h11, 32'h40080040, 4'b1100, wd, 1, 32'h0, 1'b1);
    n_cmp++; if (fmt_hs(o) != fmt_hs(e)) begin n_fail++; $display("FAIL bp_hs: got %s want %s", fmt_hs(o), fmt_hs(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL bp_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
    drive_txn(3'd4, 2'd2, 8'h12, 32'h40080044, 4'hF, 32'h0, 0, rd, 1'b0, 0, o);
    e = model(3'd4, 2'd2, 8'h12, 32'h40080044, 4'hF, 32'h0, 0, rd, 1'b0);
    n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL b2b_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL b2b_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    a_valid_i = 1'b1; a_opcode_i = 3'd4; a_size_i = 2'd2; a_source_i = 8'h77;
    a_address_i = 32'h40080100; a_mask_i = 4'hF; a_data_i = 32'h0;
    @(posedge clk_i); #1;
    a_valid_i = 1'b0; reg_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (reg_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got req=%b want 1", reg_req_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({reg_req_o, d_valid_o, a_ready_o} !== 3'b001) begin
      n_fail++; $display("FAIL rst_async_drop: got req/dv/rdy=%b want 001", {reg_req_o, d_valid_o, a_ready_o});
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    drive_txn(3'd4, 2'd2, 8'h78, 32'h40080104, 4'hF, 32'h0, 1, 32'h600DCAFE, 1'b0, 0, o);
    e = model(3'd4, 2'd2, 8'h78, 32'h40080104, 4'hF, 32'h0, 1, 32'h600DCAFE, 1'b0);
    n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL rst_after_timing: got %s want %s", fmt_timing(o), fmt_timing(e)); end
    n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL rst_after_rsp: got %s want %s", fmt_rsp(o), fmt_rsp(e)); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [2:0] op;
    logic [1:0] size;
    logic [31:0] addr, wd, rd;
    logic [3:0] mask;
    logic [7:0] src;
    logic err;
    int ad;
    int dr;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: op = 3'd0;
        1: op = 3'd1;
        2, 3: op = 3'd4;
        default: op = 3'($urandom);
      endcase
      size = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      addr = ($urandom_range(0, 5) == 0) ? $urandom : BASE + ($urandom & 32'h0000FFFF);
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
      mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      src = 8'($urandom); wd = $urandom; rd = $urandom;
      err = ($urandom_range(0, 4) == 0);
      ad = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      dr = $urandom_range(0, 3);
      drive_txn(op, size, src, addr, mask, wd, ad, rd, err, dr, o);
      e = model(op, size, src, addr, mask, wd, ad, rd, err);
      n_cmp++; if (fmt_timing(o) != fmt_timing(e)) begin n_fail++; $display("FAIL rand_timing[%0d]: got %s want %s", i, fmt_timing(o), fmt_timing(e)); end
      n_cmp++; if (fmt_rsp(o) != fmt_rsp(e)) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %s want %s", i, fmt_rsp(o), fmt_rsp(e)); end
      n_cmp++; if (fmt_hs(o) != fmt_hs(e)) begin n_fail++; $display("FAIL rand_hs[%0d]: got %s want %s", i, fmt_hs(o), fmt_hs(e)); end
      if (e.req_cycles > 0) begin
        n_cmp++; if (fmt_reg(o) != fmt_reg(e)) begin n_fail++; $display("FAIL rand_reg[%0d]: got %s want %s", i, fmt_reg(o), fmt_reg(e)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_get_ack();
    test_put_partial();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
